// File: rtl/mem_pkg.sv
// Shared types and constants for the SRAM/MMIO memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [15:0] MMIO_ADDR           = 16'hFFFF;
  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;
  localparam int unsigned SRAM_ADDR_W         = 20;

  function automatic logic is_mmio_addr(input logic [15:0] addr);
    return addr == MMIO_ADDR;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side request/response bundle between the CPU and mem_responder.
interface mem_responder_if;
  logic        MEM_EN;
  logic        WE;
  logic [15:0] ADDR;
  logic [15:0] WDATA;
  logic [15:0] RDATA;
  logic        R;

  modport master (output MEM_EN, WE, ADDR, WDATA, input  RDATA, R);
  modport slave  (input  MEM_EN, WE, ADDR, WDATA, output RDATA, R);
endinterface

// File: rtl/mem_mmio.sv
// MMIO decode and hex-display register. Compiled in only when MMIO_EN is
// defined; otherwise the decode never hits and HEX_OUT is constant zero.
module mem_mmio
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] i_addr,
  input  logic        i_wr_stb,
  input  logic [15:0] i_wdata,
  input  logic [15:0] i_switches,
  output logic        o_hit,
  output logic [15:0] o_rd_data,
  output logic [15:0] o_hex
);

`ifdef MMIO_EN
  logic [15:0] r_hex;

  assign o_hit     = is_mmio_addr(i_addr);
  assign o_rd_data = i_switches;
  assign o_hex     = r_hex;

  // Hex register loads on the final access cycle of an MMIO write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hex <= '0;
    end else if (i_wr_stb) begin
      r_hex <= i_wdata;
    end
  end
`else
  logic w_unused;

  assign o_hit     = 1'b0;
  assign o_rd_data = '0;
  assign o_hex     = '0;
  assign w_unused  = ^{clk, rst_n, i_addr, i_wr_stb, i_wdata, i_switches};
`endif

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency SRAM responder for a 16-bit CPU. Optional MMIO at 16'hFFFF
// (switches read / hex-display write) is enabled by defining MMIO_EN.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic                   Clk,
  input  logic                   Reset,
  mem_responder_if.slave         bus,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic [15:0]            SRAM_DQ_OUT,
  output logic                   SRAM_DQ_OE,
  input  logic [15:0]            SRAM_DQ_IN,
  input  logic [15:0]            Switches,
  output logic [15:0]            HEX_OUT
);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic        r_mmio;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        r_ready;
  logic        r_ce_n;
  logic        r_oe_n;
  logic        r_we_n;
  logic        r_be_n;
  logic        r_dq_oe;

  logic        w_hit;
  logic        w_last;
  logic [15:0] w_mmio_rd;

  assign w_last = (r_state == ACCESS) && (r_cnt == 4'd0);

  mem_mmio u_mmio (
    .clk        (Clk),
    .rst_n      (Reset),
    .i_addr     (bus.ADDR),
    .i_wr_stb   (w_last && r_we && r_mmio),
    .i_wdata    (r_wdata),
    .i_switches (Switches),
    .o_hit      (w_hit),
    .o_rd_data  (w_mmio_rd),
    .o_hex      (HEX_OUT)
  );

  // Request FSM; strobes are registered so they change only on state edges,
  // and the MMIO decode is taken at accept so strobes never glitch low for it.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_mmio  <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_be_n  <= 1'b1;
      r_dq_oe <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.MEM_EN) begin
            r_state <= ACCESS;
            r_cnt   <= 4'(WAIT_CYCLES - 1);
            r_we    <= bus.WE;
            r_addr  <= bus.ADDR;
            r_wdata <= bus.WDATA;
            r_mmio  <= w_hit;
            if (!w_hit) begin
              r_ce_n <= 1'b0;
              r_be_n <= 1'b0;
              if (bus.WE) begin
                r_we_n  <= 1'b0;
                r_dq_oe <= 1'b1;
              end else begin
                r_oe_n  <= 1'b0;
              end
            end
          end
        end
        ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state <= DONE;
            r_ready <= 1'b1;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_be_n  <= 1'b1;
            r_dq_oe <= 1'b0;
            if (!r_we) begin
              r_rdata <= r_mmio ? w_mmio_rd : SRAM_DQ_IN;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          r_state <= RELEASE;
        end
        RELEASE: begin
          if (!bus.MEM_EN) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.R       = r_ready;
  assign bus.RDATA   = r_rdata;
  assign SRAM_ADDR   = {4'h0, r_addr};
  assign SRAM_CE_N   = r_ce_n;
  assign SRAM_OE_N   = r_oe_n;
  assign SRAM_WE_N   = r_we_n;
  assign SRAM_UB_N   = r_be_n;
  assign SRAM_LB_N   = r_be_n;
  assign SRAM_DQ_OUT = r_wdata;
  assign SRAM_DQ_OE  = r_dq_oe;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, giving the number of SRAM access cycles per request (legal range 1..15).
REQ-002 Clk  input  1  the single clock; all state SHALL be updated on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset.
REQ-004 MEM_EN  input  1  CPU memory request strobe.
REQ-005 WE  input  1  request direction: 1 = write, 0 = read.
REQ-006 ADDR  input  16  request address (CPU MAR).
REQ-007 WDATA  input  16  write data (CPU MDR).
REQ-008 RDATA  output  16  read data returned to the CPU MDR input.
REQ-009 R  output  1  ready; a one-cycle pulse that completes the request.
REQ-010 SRAM_ADDR  output  20  the SRAM address, equal to {4'h0, latched ADDR}.
REQ-011 SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  SRAM strobes, all active-low.
REQ-012 SRAM_DQ_OUT  output  16  write data driven to the SRAM.
REQ-013 SRAM_DQ_OE  output  1  tristate enable for SRAM_DQ_OUT, used by the top-level tristate.
REQ-014 SRAM_DQ_IN  input  16  SRAM read data.
REQ-015 Switches  input  16  board switches, readable through MMIO.
REQ-016 HEX_OUT  output  16  hex-display register, writable through MMIO.

Function
REQ-017 The state machine SHALL have the states IDLE, ACCESS, DONE and RELEASE.
- IDLE: accepts a request when MEM_EN=1; latches ADDR, WE and WDATA; moves to ACCESS.
- ACCESS: lasts exactly WAIT_CYCLES cycles, then moves to DONE.
- DONE: lasts one cycle with R=1, then moves to RELEASE.
- RELEASE: returns to IDLE on the first cycle in which MEM_EN=0.
REQ-018 Latency SHALL be fixed: R is high in cycle WAIT_CYCLES+1 after the accept edge, for both reads and writes.
REQ-019 Changes on ADDR, WE or WDATA after the accept edge SHALL be ignored until the next accept.
REQ-020 During ACCESS: SRAM_CE_N=0 and SRAM_UB_N=SRAM_LB_N=0.
- Read: SRAM_OE_N=0 and SRAM_DQ_OE=0.
- Write: SRAM_WE_N=0, SRAM_DQ_OE=1 and SRAM_DQ_OUT equal to the latched WDATA.
REQ-021 Outside ACCESS, every SRAM strobe SHALL be 1 and SRAM_DQ_OE SHALL be 0.
REQ-022 On a read, RDATA SHALL capture SRAM_DQ_IN on the last ACCESS cycle, be valid while R=1, and hold until the next read completes.
REQ-023 A write SHALL leave RDATA unchanged.
REQ-024 MEM_EN held high through DONE SHALL NOT start a second request; one cycle with MEM_EN=0 is required between requests.
REQ-025 R SHALL never be asserted outside DONE.

Reset
REQ-026 While Reset=0, the block SHALL immediately, without waiting for a clock edge:
- enter IDLE;
- drive R=0, RDATA=16'h0000 and HEX_OUT=16'h0000;
- drive every SRAM strobe to 1 and SRAM_DQ_OE to 0.
REQ-027 A reset during ACCESS SHALL abort the request with no R pulse; a write may be left partially performed.

Configuration
REQ-028 With MMIO_EN defined, address 16'hFFFF SHALL be decoded as memory-mapped I/O:
- a read returns Switches, sampled on the last ACCESS cycle;
- a write loads HEX_OUT on the last ACCESS cycle;
- all SRAM strobes stay 1 and the latency is unchanged.
REQ-029 Without MMIO_EN, address 16'hFFFF SHALL be ordinary SRAM, Switches SHALL be ignored, and HEX_OUT SHALL be a constant 16'h0000.

Structure
REQ-030 Package mem_pkg SHALL hold:
- the state enum;
- the constant MMIO_ADDR = 16'hFFFF;
- the default wait count;
- the SRAM address width (20).
REQ-031 The MMIO address decode and the HEX_OUT register SHALL be one sub-module, mem_mmio; the FSM and the wait counter stay in mem_responder.

Verification
REQ-032 Read, WAIT_CYCLES=2, ADDR=16'h3000, SRAM_DQ_IN=16'hBEEF -> SRAM_OE_N=0 for 2 cycles, R pulses in cycle 3, RDATA=16'hBEEF, SRAM_ADDR=20'h03000.
REQ-033 Write, ADDR=16'h0010, WDATA=16'h1234 -> SRAM_WE_N=0 and SRAM_DQ_OE=1 with SRAM_DQ_OUT=16'h1234 for 2 cycles, R pulses once, RDATA unchanged.
REQ-034 MEM_EN held high for 10 cycles -> exactly one R pulse; after one low cycle, a second request is accepted.
REQ-035 Reset driven low in the second ACCESS cycle of a write -> strobes go high asynchronously, R is never seen, HEX_OUT=16'h0000.
REQ-036 MMIO_EN defined:
- write 16'h00A5 to 16'hFFFF -> HEX_OUT=16'h00A5 and SRAM_CE_N stays 1;
- with Switches=16'h0F0F, read 16'hFFFF -> RDATA=16'h0F0F.
REQ-037 MMIO_EN undefined: the same read of 16'hFFFF drives SRAM_CE_N=0 and returns SRAM_DQ_IN.
